nes_controller_responder: RTL and testbench

//  Controller-side (responder) end of the NES serial pad protocol, the counterpart of the console-side NES receiver.

---
 rtl/nes_controller_responder.sv | 143 ++++++++++++++
 tb/tb_nes_controller_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_responder.sv
// nes_controller_responder: CD4021-style NES/SNES pad emulator; latches a button word, shifts it out LSB first.
// Optional turbo on buttons A/B is compiled in when NES_TURBO_EN is defined.
module nes_controller_responder #(
    parameter int   NUM_BITS     = 8,
    parameter int   SYNC_STAGES  = 2,
    parameter logic TAIL_LEVEL   = 1'b1
`ifdef NES_TURBO_EN
    ,
    parameter int   TURBO_PERIOD = 4
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] buttons,
    input  logic                nes_latch,
    input  logic                nes_clk,
`ifdef NES_TURBO_EN
    input  logic [1:0]          turbo_mask,
`endif
    output logic                nes_data,
    output logic                busy,
    output logic                poll_done
);

    localparam int CW = $clog2(NUM_BITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   latch_d;
    logic                   clk_d;
    logic                   latch_s;
    logic                   clk_s;
    logic                   latch_fall;
    logic                   clk_rise;

    logic [1:0]             state;
    logic [NUM_BITS-1:0]    shift_reg;
    logic [NUM_BITS-1:0]    shifted;
    logic [NUM_BITS-1:0]    eff_buttons;
    logic [CW-1:0]          count;

    // Both host lines are asynchronous to clk; the extra flop after each chain feeds edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            latch_d    <= 1'b0;
            clk_d      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], nes_clk};
            latch_d    <= latch_s;
            clk_d      <= clk_s;
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_fall = latch_d & ~latch_s;
    assign clk_rise   = clk_s & ~clk_d;

`ifdef NES_TURBO_EN
    localparam int PW = $clog2(2 * TURBO_PERIOD);

    logic [PW-1:0] poll_cnt;
    logic          turbo_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (latch_fall) begin
            poll_cnt <= (poll_cnt == PW'(2 * TURBO_PERIOD - 1)) ? '0 : poll_cnt + PW'(1);
        end
    end

    assign turbo_on = (poll_cnt < PW'(TURBO_PERIOD));

    // Turbo-masked A/B are forced released during the second half of each turbo cycle.
    always_comb begin
        eff_buttons    = buttons;
        eff_buttons[0] = buttons[0] & (turbo_on | ~turbo_mask[0]);
        eff_buttons[1] = buttons[1] & (turbo_on | ~turbo_mask[1]);
    end
`else
    assign eff_buttons = buttons;
`endif

    assign shifted = shift_reg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            count     <= '0;
            nes_data  <= TAIL_LEVEL;
            poll_done <= 1'b0;
        end else begin
            poll_done <= 1'b0;
            // A high latch always wins: it aborts any poll and discards a coincident clock edge.
            if (latch_s) begin
                state     <= S_LOAD;
                shift_reg <= eff_buttons;
                count     <= '0;
                nes_data  <= ~eff_buttons[0];
            end else begin
                case (state)
                    S_LOAD: begin
                        if (latch_fall) begin
                            state <= S_SHIFT;
                            count <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (clk_rise) begin
                            shift_reg <= shifted;
                            if (count == CW'(NUM_BITS - 1)) begin
                                state     <= S_DONE;
                                count     <= CW'(NUM_BITS);
                                nes_data  <= TAIL_LEVEL;
                                poll_done <= 1'b1;
                            end else begin
                                count    <= count + CW'(1);
                                nes_data <= ~shifted[0];
                            end
                        end
                    end
                    default: begin
                        nes_data <= TAIL_LEVEL;
                    end
                endcase
            end
        end
    end

    assign busy = (state == S_LOAD) || (state == S_SHIFT);

endmodule

// File: tb/tb_nes_controller_responder.sv
// Self-checking bench for nes_controller_responder: host-side latch/clock stimulus against a pad model.
// Compile with NES_TURBO_EN defined to also exercise the turbo feature.
`timescale 1ns/1ps
module tb_nes_controller_responder;

    localparam int   NB        = 8;
    localparam logic TAIL      = 1'b1;
    localparam int   TURBO_PER = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          nes_latch = 1'b0;
    logic          nes_clk   = 1'b0;
    logic [NB-1:0] buttons   = '0;
    logic [1:0]    turbo_mask = 2'b00;
    logic          nes_data;
    logic          busy;
    logic          poll_done;

    int   checks    = 0;
    int   errors    = 0;
    int   done_cnt  = 0;
    int   done_wide = 0;
    int   poll_idx  = 0;
    logic done_prev = 1'b0;

    nes_controller_responder #(
        .NUM_BITS   (NB),
        .SYNC_STAGES(2),
        .TAIL_LEVEL (TAIL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buttons   (buttons),
        .nes_latch (nes_latch),
        .nes_clk   (nes_clk),
`ifdef NES_TURBO_EN
        .turbo_mask(turbo_mask),
`endif
        .nes_data  (nes_data),
        .busy      (busy),
        .poll_done (poll_done)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (poll_done) begin
            done_cnt++;
            if (done_prev) done_wide++;
        end
        done_prev = poll_done;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1);
    end

    // Pad model: value captured by poll number poll_idx (turbo halves counted from reset).
    function automatic logic [NB-1:0] model_load(input logic [NB-1:0] b);
        logic [NB-1:0] r;
        r = b;
        if ((poll_idx % (2 * TURBO_PER)) >= TURBO_PER) begin
            if (turbo_mask[0]) r[0] = 1'b0;
            if (turbo_mask[1]) r[1] = 1'b0;
        end
        return r;
    endfunction

    // Host-visible stream: active-low bits, LSB first, then the tail level.
    function automatic logic [NB:0] exp_stream(input logic [NB-1:0] loaded);
        return {TAIL, ~loaded};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_latch(output logic [NB-1:0] loaded);
        loaded    = model_load(buttons);
        nes_latch = 1'b1;
        tick(8);
        nes_latch = 1'b0;
        poll_idx++;
        tick(8);
    endtask

    task automatic clk_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            nes_clk = 1'b1;
            tick(6);
            nes_clk = 1'b0;
            tick(6);
        end
    endtask

    task automatic read_stream(output logic [NB:0] got);
        @(negedge clk);
        got[0] = nes_data;
        for (int i = 1; i <= NB; i++) begin
            nes_clk = 1'b1;
            tick(6);
            @(negedge clk);
            got[i] = nes_data;
            nes_clk = 1'b0;
            tick(6);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        poll_idx = 0;
        tick(2);
    endtask

    task automatic test_reset();
        nes_latch = 1'b0;
        nes_clk   = 1'b0;
        apply_reset();
        @(negedge clk);
        checks++; if (nes_data !== TAIL) begin errors++; $display("FAIL reset_data: got %b want %b", nes_data, TAIL); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (poll_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", poll_done); end
        clk_pulses(3);
        @(negedge clk);
        checks++; if (nes_data !== TAIL) begin errors++; $display("FAIL idle_clk_data: got %b want %b", nes_data, TAIL); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_clk_busy: got %b want 0", busy); end
    endtask

    task automatic test_latency();
        buttons = 8'h01;
        @(posedge clk); #1;
        nes_latch = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c < 3) begin
                checks++; if (nes_data !== TAIL) begin errors++; $display("FAIL latency_early_c%0d: got %b want %b", c, nes_data, TAIL); end
            end else begin
                checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL latency_c3: got %b want 0", nes_data); end
            end
        end
        tick(4);
        nes_latch = 1'b0;
        poll_idx++;
        tick(8);
    endtask

    task automatic test_basic();
        logic [NB-1:0] loaded;
        logic [NB:0]   got;
        int            d0;
        buttons = 8'b1000_0001;
        host_latch(loaded);
        d0 = done_cnt;
        read_stream(got);
        checks++; if (got !== exp_stream(loaded)) begin errors++; $display("FAIL basic_stream: got %b want %b", got, exp_stream(loaded)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_random_polls();
        logic [NB-1:0] loaded;
        logic [NB:0]   got;
        int            d0;
        for (int i = 0; i < 6; i++) begin
            buttons = NB'($urandom);
            host_latch(loaded);
            @(negedge clk);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rand%0d_busy: got %b want 1", i, busy); end
            d0 = done_cnt;
            read_stream(got);
            checks++; if (got !== exp_stream(loaded)) begin errors++; $display("FAIL rand%0d_stream: got %b want %b", i, got, exp_stream(loaded)); end
            checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rand%0d_done: got %0d want 1", i, done_cnt - d0); end
        end
    endtask

    task automatic test_abort();
        logic [NB-1:0] loaded;
        logic [NB:0]   got;
        int            d0;
        buttons = 8'hFF;
        host_latch(loaded);
        d0 = done_cnt;
        clk_pulses(3);
        buttons = NB'($urandom) | 8'h01;
        host_latch(loaded);
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
        @(negedge clk);
        checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL abort_bit0: got %b want 0", nes_data); end
        read_stream(got);
        checks++; if (got !== exp_stream(loaded)) begin errors++; $display("FAIL abort_stream: got %b want %b", got, exp_stream(loaded)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_buttons_change();
        logic [NB-1:0] loaded;
        logic [NB:0]   got;
        buttons = NB'($urandom);
        host_latch(loaded);
        buttons = 8'h00;
        read_stream(got);
        checks++; if (got !== exp_stream(loaded)) begin errors++; $display("FAIL hold_stream: got %b want %b", got, exp_stream(loaded)); end
    endtask

    task automatic test_same_cycle();
        logic [NB-1:0] loaded;
        logic [NB:0]   got;
        int            d0;
        buttons = NB'($urandom);
        host_latch(loaded);
        d0 = done_cnt;
        clk_pulses(2);
        buttons = NB'($urandom) ^ 8'h5A;
        loaded  = model_load(buttons);
        @(posedge clk); #1;
        nes_latch = 1'b1;
        nes_clk   = 1'b1;
        tick(6);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", busy); end
        checks++; if (nes_data !== ~loaded[0]) begin errors++; $display("FAIL same_bit0: got %b want %b", nes_data, ~loaded[0]); end
        nes_clk = 1'b0;
        tick(4);
        nes_latch = 1'b0;
        poll_idx++;
        tick(8);
        read_stream(got);
        checks++; if (got !== exp_stream(loaded)) begin errors++; $display("FAIL same_stream: got %b want %b", got, exp_stream(loaded)); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL same_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_extra_clocks();
        int d0;
        d0 = done_cnt;
        clk_pulses(4);
        @(negedge clk);
        checks++; if (nes_data !== TAIL) begin errors++; $display("FAIL extra_data: got %b want %b", nes_data, TAIL); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL extra_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_poll();
        logic [NB-1:0] loaded;
        int            d0;
        buttons = 8'hFF;
        host_latch(loaded);
        clk_pulses(3);
        d0 = done_cnt;
        rst_n = 1'b0;
        #2;
        checks++; if (nes_data !== TAIL) begin errors++; $display("FAIL rst_mid_data: got %b want %b", nes_data, TAIL); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        tick(2);
        rst_n = 1'b1;
        poll_idx = 0;
        tick(2);
        clk_pulses(6);
        @(negedge clk);
        checks++; if (nes_data !== TAIL) begin errors++; $display("FAIL rst_post_data: got %b want %b", nes_data, TAIL); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_post_busy: got %b want 0", busy); end
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL rst_post_done: got %0d want 0", done_cnt - d0); end
    endtask

`ifdef NES_TURBO_EN
    task automatic test_turbo();
        logic [NB-1:0] loaded;
        apply_reset();
        turbo_mask = 2'b01;
        buttons    = 8'h03;
        for (int p = 0; p < 16; p++) begin
            host_latch(loaded);
            @(negedge clk);
            checks++; if (nes_data !== ~loaded[0]) begin errors++; $display("FAIL turbo_a_poll%0d: got %b want %b", p, nes_data, ~loaded[0]); end
            clk_pulses(1);
            @(negedge clk);
            checks++; if (nes_data !== 1'b0) begin errors++; $display("FAIL turbo_b_poll%0d: got %b want 0", p, nes_data); end
        end
        turbo_mask = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_random_polls();
        test_abort();
        test_buttons_change();
        test_extra_clocks();
        test_same_cycle();
        test_reset_mid_poll();
`ifdef NES_TURBO_EN
        test_turbo();
`endif
        checks++; if (done_wide != 0) begin errors++; $display("FAIL done_width: got %0d wide pulses want 0", done_wide); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
